// File: rtl/sd_host_pkg.sv
// Shared SD host definitions: error codes, data-phase sequencer states and
// byte-mode defaults used across the SD-domain blocks.
package sd_host_pkg;

  localparam logic [7:0] SD_ERR_NONE  = 8'h00;
  localparam logic [7:0] SD_ERR_SIZE  = 8'h01;
  localparam logic [7:0] SD_ERR_BSIZE = 8'h02;
  localparam logic [7:0] SD_ERR_CRC   = 8'h04;
  localparam logic [7:0] SD_ERR_ABORT = 8'h08;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_ACTIVE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_SLEEP  = 3'd4,
    ST_DONE   = 3'd5
  } seq_state_t;

  // A byte-mode request of size 0 means a full 512-byte block.
  localparam int SD_BYTE_MODE_DEFAULT = 512;

endpackage

// File: rtl/sd_block_sequencer_if.sv
// Sequencer-to-PHY data engine link: block activation level, byte count and
// direction out; block completion pulse and CRC status back.
interface sd_block_sequencer_if #(
  parameter int BYTE_CNT_WIDTH = 12
);
  logic                      o_phy_activate;
  logic [BYTE_CNT_WIDTH-1:0] o_phy_byte_count;
  logic                      o_phy_write_flag;
  logic                      i_phy_finished;
  logic                      i_phy_crc_err;

  modport master (
    output o_phy_activate,
    output o_phy_byte_count,
    output o_phy_write_flag,
    input  i_phy_finished,
    input  i_phy_crc_err
  );

  modport slave (
    input  o_phy_activate,
    input  o_phy_byte_count,
    input  o_phy_write_flag,
    output i_phy_finished,
    output i_phy_crc_err
  );
endinterface

// File: rtl/sd_sleep_timer.sv
// Loadable down-counter with a zero flag; paces inter-block gaps and is also
// used as the command timeout counter.
module sd_sleep_timer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             count_en,
  output logic             done
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (count_en && (count_reg != '0)) begin
      count_reg <= count_reg - WIDTH'(1);
    end
  end

  assign done = (count_reg == '0);

endmodule

// File: rtl/sd_block_sequencer.sv
// SD data-phase sequencer: splits one byte/block-mode request into PHY block
// transfers with per-function block size, inter-block sleep, CRC retry and abort.
module sd_block_sequencer
  import sd_host_pkg::*;
#(
  parameter int NUM_FUNCS      = 8,
  parameter int SIZE_WIDTH     = 24,
  parameter int BYTE_CNT_WIDTH = 12,
  parameter int SLEEP_WIDTH    = 32,
  parameter int MAX_RETRY      = 2,
  localparam int FUNC_W        = (NUM_FUNCS > 1) ? $clog2(NUM_FUNCS) : 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            i_start,
  input  logic                            i_write_flag,
  input  logic                            i_block_mode,
  input  logic                            i_mem_sel,
  input  logic [FUNC_W-1:0]               i_func_addr,
  input  logic [SIZE_WIDTH-1:0]           i_data_size,
  input  logic [NUM_FUNCS*SIZE_WIDTH-1:0] i_block_sizes,
  input  logic [SIZE_WIDTH-1:0]           i_mem_block_size,
  input  logic [SLEEP_WIDTH-1:0]          i_sleep_count,
  input  logic                            i_abort,
  output logic                            o_busy,
  output logic                            o_finished,
  output logic                            o_error_flag,
  output logic [7:0]                      o_error,
  output logic [SIZE_WIDTH-1:0]           o_blocks_done,
  sd_block_sequencer_if.master            phy
);

  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  seq_state_t                state_reg, state_next;
  logic                      write_flag_reg, block_mode_reg, mem_sel_reg;
  logic [FUNC_W-1:0]         func_addr_reg;
  logic [SIZE_WIDTH-1:0]     data_size_reg, total_blocks_reg, blocks_done_reg;
  logic [SLEEP_WIDTH-1:0]    sleep_count_reg;
  logic [BYTE_CNT_WIDTH-1:0] byte_count_reg;
  logic [RETRY_W-1:0]        retry_reg;
  logic                      crc_err_reg;
  logic [7:0]                error_reg;
  logic                      error_flag_reg;

  logic [SIZE_WIDTH-1:0]     size_table [NUM_FUNCS];
  logic [SIZE_WIDTH-1:0]     block_size;
  logic [BYTE_CNT_WIDTH-1:0] byte_mode_count;
  logic                      block_size_bad, byte_size_bad, last_block, retry_left, reissue_sleep;
  logic                      timer_load, timer_en, timer_done;
  logic [SLEEP_WIDTH-1:0]    timer_value;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_FUNCS; gi++) begin : g_table
      assign size_table[gi] = i_block_sizes[gi*SIZE_WIDTH +: SIZE_WIDTH];
    end
  endgenerate

  // Any bit above the PHY byte-count field means the size cannot be expressed.
  assign block_size      = mem_sel_reg ? i_mem_block_size : size_table[func_addr_reg];
  assign block_size_bad  = (block_size == '0) || (|block_size[SIZE_WIDTH-1:BYTE_CNT_WIDTH]);
  assign byte_size_bad   = data_size_reg > SIZE_WIDTH'(SD_BYTE_MODE_DEFAULT);
  assign byte_mode_count = (data_size_reg == '0) ? BYTE_CNT_WIDTH'(SD_BYTE_MODE_DEFAULT)
                                                 : data_size_reg[BYTE_CNT_WIDTH-1:0];
  assign last_block      = (blocks_done_reg + SIZE_WIDTH'(1)) == total_blocks_reg;
  assign retry_left      = retry_reg < RETRY_W'(MAX_RETRY);
  // CHECK itself is one idle cycle, so SLEEP only covers the remainder.
  assign reissue_sleep   = sleep_count_reg > SLEEP_WIDTH'(1);
  assign timer_value     = sleep_count_reg - SLEEP_WIDTH'(2);

  sd_sleep_timer #(.WIDTH(SLEEP_WIDTH)) u_sleep_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (timer_load),
    .load_value (timer_value),
    .count_en   (timer_en),
    .done       (timer_done)
  );

  always_comb begin
    state_next = state_reg;
    timer_load = 1'b0;
    timer_en   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (i_start) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        if (i_abort)
          state_next = ST_DONE;
        else if (block_mode_reg)
          state_next = ((data_size_reg == '0) || block_size_bad) ? ST_DONE : ST_ACTIVE;
        else
          state_next = byte_size_bad ? ST_DONE : ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (i_abort)                  state_next = ST_DONE;
        else if (phy.i_phy_finished)  state_next = ST_CHECK;
      end
      ST_CHECK: begin
        if (i_abort) begin
          state_next = ST_DONE;
        end else if (!crc_err_reg ? last_block : !retry_left) begin
          state_next = ST_DONE;
        end else if (reissue_sleep) begin
          state_next = ST_SLEEP;
          timer_load = 1'b1;
        end else begin
          state_next = ST_ACTIVE;
        end
      end
      ST_SLEEP: begin
        if (i_abort)         state_next = ST_DONE;
        else if (timer_done) state_next = ST_ACTIVE;
        else                 timer_en   = 1'b1;
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= ST_IDLE;
      write_flag_reg   <= 1'b0;
      block_mode_reg   <= 1'b0;
      mem_sel_reg      <= 1'b0;
      func_addr_reg    <= '0;
      data_size_reg    <= '0;
      sleep_count_reg  <= '0;
      total_blocks_reg <= '0;
      blocks_done_reg  <= '0;
      byte_count_reg   <= '0;
      retry_reg        <= '0;
      crc_err_reg      <= 1'b0;
      error_reg        <= SD_ERR_NONE;
      error_flag_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        ST_IDLE: begin
          if (i_start) begin
            write_flag_reg  <= i_write_flag;
            block_mode_reg  <= i_block_mode;
            mem_sel_reg     <= i_mem_sel;
            func_addr_reg   <= i_func_addr;
            data_size_reg   <= i_data_size;
            sleep_count_reg <= i_sleep_count;
            blocks_done_reg <= '0;
            retry_reg       <= '0;
            error_reg       <= SD_ERR_NONE;
            error_flag_reg  <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (block_mode_reg) begin
            total_blocks_reg <= data_size_reg;
            byte_count_reg   <= block_size[BYTE_CNT_WIDTH-1:0];
          end else begin
            total_blocks_reg <= SIZE_WIDTH'(1);
            byte_count_reg   <= byte_mode_count;
          end
          if (i_abort) begin
            error_reg      <= SD_ERR_ABORT;
            error_flag_reg <= 1'b1;
          end else if (block_mode_reg && (data_size_reg != '0) && block_size_bad) begin
            error_reg      <= SD_ERR_BSIZE;
            error_flag_reg <= 1'b1;
          end else if (!block_mode_reg && byte_size_bad) begin
            error_reg      <= SD_ERR_SIZE;
            error_flag_reg <= 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (i_abort) begin
            error_reg      <= SD_ERR_ABORT;
            error_flag_reg <= 1'b1;
          end else if (phy.i_phy_finished) begin
            crc_err_reg <= phy.i_phy_crc_err;
          end
        end
        ST_CHECK: begin
          if (i_abort) begin
            error_reg      <= SD_ERR_ABORT;
            error_flag_reg <= 1'b1;
          end else if (!crc_err_reg) begin
            blocks_done_reg <= blocks_done_reg + SIZE_WIDTH'(1);
            retry_reg       <= '0;
          end else if (retry_left) begin
            retry_reg <= retry_reg + RETRY_W'(1);
          end else begin
            error_reg      <= SD_ERR_CRC;
            error_flag_reg <= 1'b1;
          end
        end
        ST_SLEEP: begin
          if (i_abort) begin
            error_reg      <= SD_ERR_ABORT;
            error_flag_reg <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy               = (state_reg != ST_IDLE);
  assign o_finished           = (state_reg == ST_DONE);
  assign o_error              = error_reg;
  assign o_error_flag         = error_flag_reg;
  assign o_blocks_done        = blocks_done_reg;
  assign phy.o_phy_activate   = (state_reg == ST_ACTIVE);
  assign phy.o_phy_byte_count = byte_count_reg;
  assign phy.o_phy_write_flag = write_flag_reg;

endmodule

// File: tb/tb_sd_block_sequencer.sv
// Directed bench for sd_block_sequencer: a scripted PHY answers each block,
// and every scenario compares against hand-computed results.
module tb_sd_block_sequencer;

  localparam int NUM_FUNCS = 8;
  localparam int SW        = 24;
  localparam int BCW       = 12;
  localparam int SLW       = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                    i_start = 1'b0, i_write_flag = 1'b0, i_block_mode = 1'b0;
  logic                    i_mem_sel = 1'b0, i_abort = 1'b0;
  logic [2:0]              i_func_addr = '0;
  logic [SW-1:0]           i_data_size = '0, i_mem_block_size = '0;
  logic [NUM_FUNCS*SW-1:0] i_block_sizes = '0;
  logic [SLW-1:0]          i_sleep_count = '0;
  logic                    o_busy, o_finished, o_error_flag;
  logic [7:0]              o_error;
  logic [SW-1:0]           o_blocks_done;
  logic                    phy_fin = 1'b0, phy_crc = 1'b0;

  sd_block_sequencer_if #(.BYTE_CNT_WIDTH(BCW)) phy_bus();
  assign phy_bus.i_phy_finished = phy_fin;
  assign phy_bus.i_phy_crc_err  = phy_crc;

  sd_block_sequencer #(
    .NUM_FUNCS(NUM_FUNCS), .SIZE_WIDTH(SW), .BYTE_CNT_WIDTH(BCW), .SLEEP_WIDTH(SLW), .MAX_RETRY(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_write_flag(i_write_flag),
    .i_block_mode(i_block_mode), .i_mem_sel(i_mem_sel), .i_func_addr(i_func_addr),
    .i_data_size(i_data_size), .i_block_sizes(i_block_sizes), .i_mem_block_size(i_mem_block_size),
    .i_sleep_count(i_sleep_count), .i_abort(i_abort), .o_busy(o_busy), .o_finished(o_finished),
    .o_error_flag(o_error_flag), .o_error(o_error), .o_blocks_done(o_blocks_done), .phy(phy_bus)
  );

  int tests_run = 0, tests_failed = 0;
  int cyc = 0, start_cyc = 0, rise_cyc = 0;
  int rises, low_run, high_run, fin_pulses, issue;
  int gap_seen [8];
  logic [BCW-1:0] bc_seen [8];
  logic act_prev = 1'b0;
  logic [15:0] crc_mask = '0;
  bit phy_auto = 1'b1;
  bit busy_at_fin, busy_after, timed_out;

  // One clock: observe outputs at the falling edge, then drive the PHY reply.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (phy_bus.o_phy_activate && !act_prev) begin
      if (rises < 8) begin
        bc_seen[rises] = phy_bus.o_phy_byte_count;
        if (rises > 0) gap_seen[rises-1] = low_run;
      end
      if (rises == 0) rise_cyc = cyc;
      rises++;
      high_run = 0;
    end
    if (phy_bus.o_phy_activate) high_run++;
    else low_run = act_prev ? 1 : low_run + 1;
    if (o_finished) begin
      fin_pulses++;
      busy_at_fin = o_busy;
    end
    act_prev = phy_bus.o_phy_activate;
    i_start = 1'b0;
    i_abort = 1'b0;
    if (phy_auto && phy_bus.o_phy_activate && high_run == 2) begin
      phy_fin = 1'b1;
      phy_crc = crc_mask[issue];
      issue++;
    end else begin
      phy_fin = 1'b0;
      phy_crc = 1'b0;
    end
  endtask

  task automatic start_req(input bit wf, input bit bm, input bit ms, input logic [2:0] fa,
                           input logic [SW-1:0] size, input logic [SLW-1:0] sleep,
                           input logic [15:0] mask);
    rises = 0; low_run = 0; high_run = 0; fin_pulses = 0; issue = 0;
    act_prev = 1'b0; busy_at_fin = 1'b0; busy_after = 1'b1; crc_mask = mask;
    for (int k = 0; k < 8; k++) begin
      bc_seen[k]  = '0;
      gap_seen[k] = -1;
    end
    i_write_flag = wf; i_block_mode = bm; i_mem_sel = ms; i_func_addr = fa;
    i_data_size = size; i_sleep_count = sleep;
    start_cyc = cyc;
    i_start = 1'b1;
    step();
  endtask

  task automatic wait_fin(input int budget, output bit to);
    int k;
    k = 0;
    while (fin_pulses == 0 && k < budget) begin
      step();
      k++;
    end
    to = (fin_pulses == 0);
    step();
    busy_after = o_busy;
    $display("[TB] req bm=%0d size=%0d -> blocks_issued=%0d done=%0d err=%02h",
             i_block_mode, i_data_size, rises, o_blocks_done, o_error);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests_run++;
    if ({o_busy, o_finished, o_error_flag, o_error, o_blocks_done, phy_bus.o_phy_activate,
         phy_bus.o_phy_byte_count, phy_bus.o_phy_write_flag} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got busy=%0d fin=%0d err=%02h done=%0d act=%0d bc=%0d wf=%0d want all 0",
               o_busy, o_finished, o_error, o_blocks_done, phy_bus.o_phy_activate,
               phy_bus.o_phy_byte_count, phy_bus.o_phy_write_flag);
    end
    rst_n = 1'b1;
    step(); step();
    tests_run++;
    if (o_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_idle: busy=%0d want 0", o_busy); end
  endtask

  task automatic test_block_mode();
    start_req(1'b1, 1'b1, 1'b0, 3'd1, 24'd3, 32'd4, 16'h0000);
    wait_fin(200, timed_out);
    tests_run++; if (timed_out !== 1'b0) begin tests_failed++; $display("FAIL blk_timeout: got 1 want 0"); end
    tests_run++; if (rises !== 3) begin tests_failed++; $display("FAIL blk_rises: got %0d want 3", rises); end
    tests_run++; if ({bc_seen[0], bc_seen[1], bc_seen[2]} !== {3{12'd64}}) begin tests_failed++;
      $display("FAIL blk_bytecount: got %0d %0d %0d want 64 64 64", bc_seen[0], bc_seen[1], bc_seen[2]); end
    tests_run++; if (gap_seen[0] !== 4 || gap_seen[1] !== 4) begin tests_failed++;
      $display("FAIL blk_gap: got %0d %0d want 4 4", gap_seen[0], gap_seen[1]); end
    tests_run++; if (rise_cyc - start_cyc !== 2) begin tests_failed++;
      $display("FAIL blk_latency: got %0d want 2", rise_cyc - start_cyc); end
    tests_run++; if (o_blocks_done !== 24'd3) begin tests_failed++; $display("FAIL blk_done: got %0d want 3", o_blocks_done); end
    tests_run++; if (o_error !== 8'h00 || o_error_flag !== 1'b0) begin tests_failed++;
      $display("FAIL blk_error: got %02h/%0d want 00/0", o_error, o_error_flag); end
    tests_run++; if (fin_pulses !== 1) begin tests_failed++; $display("FAIL blk_finished: got %0d pulses want 1", fin_pulses); end
    tests_run++; if (busy_at_fin !== 1'b1 || busy_after !== 1'b0) begin tests_failed++;
      $display("FAIL blk_busy: got %0d,%0d want 1,0", busy_at_fin, busy_after); end
    tests_run++; if (phy_bus.o_phy_write_flag !== 1'b1) begin tests_failed++;
      $display("FAIL blk_wflag: got %0d want 1", phy_bus.o_phy_write_flag); end
  endtask

  task automatic test_byte_mode();
    start_req(1'b0, 1'b0, 1'b0, 3'd0, 24'd0, 32'd0, 16'h0000);
    wait_fin(100, timed_out);
    tests_run++; if (timed_out !== 1'b0 || rises !== 1 || bc_seen[0] !== 12'd512) begin tests_failed++;
      $display("FAIL byte0: got to=%0d rises=%0d bc=%0d want 0 1 512", timed_out, rises, bc_seen[0]); end
    tests_run++; if (o_blocks_done !== 24'd1 || o_error !== 8'h00) begin tests_failed++;
      $display("FAIL byte0_status: got done=%0d err=%02h want 1 00", o_blocks_done, o_error); end
    start_req(1'b0, 1'b0, 1'b0, 3'd0, 24'd512, 32'd0, 16'h0000);
    wait_fin(100, timed_out);
    tests_run++; if (rises !== 1 || bc_seen[0] !== 12'd512 || o_error !== 8'h00) begin tests_failed++;
      $display("FAIL byte512: got rises=%0d bc=%0d err=%02h want 1 512 00", rises, bc_seen[0], o_error); end
    start_req(1'b0, 1'b0, 1'b0, 3'd0, 24'd600, 32'd0, 16'h0000);
    wait_fin(100, timed_out);
    tests_run++; if (timed_out !== 1'b0 || rises !== 0 || fin_pulses !== 1) begin tests_failed++;
      $display("FAIL byte600: got to=%0d rises=%0d fin=%0d want 0 0 1", timed_out, rises, fin_pulses); end
    tests_run++; if (o_error !== 8'h01 || o_error_flag !== 1'b1 || o_blocks_done !== '0) begin tests_failed++;
      $display("FAIL byte600_err: got %02h/%0d done=%0d want 01/1 0", o_error, o_error_flag, o_blocks_done); end
    start_req(1'b0, 1'b0, 1'b0, 3'd0, 24'd513, 32'd0, 16'h0000);
    wait_fin(100, timed_out);
    tests_run++; if (o_error !== 8'h01 || rises !== 0) begin tests_failed++;
      $display("FAIL byte513: got err=%02h rises=%0d want 01 0", o_error, rises); end
  endtask

  task automatic test_crc_retry();
    start_req(1'b0, 1'b1, 1'b0, 3'd3, 24'd3, 32'd0, 16'b00110);
    wait_fin(200, timed_out);
    tests_run++; if (timed_out !== 1'b0 || rises !== 5) begin tests_failed++;
      $display("FAIL retry_rises: got to=%0d rises=%0d want 0 5", timed_out, rises); end
    tests_run++; if (o_blocks_done !== 24'd3 || o_error !== 8'h00) begin tests_failed++;
      $display("FAIL retry_status: got done=%0d err=%02h want 3 00", o_blocks_done, o_error); end
    tests_run++; if (gap_seen[1] !== 1 || bc_seen[2] !== 12'd16) begin tests_failed++;
      $display("FAIL retry_gap: got gap=%0d bc=%0d want 1 16", gap_seen[1], bc_seen[2]); end
    start_req(1'b0, 1'b1, 1'b0, 3'd1, 24'd3, 32'd2, 16'b01110);
    wait_fin(200, timed_out);
    tests_run++; if (timed_out !== 1'b0 || rises !== 4) begin tests_failed++;
      $display("FAIL crcfail_rises: got to=%0d rises=%0d want 0 4", timed_out, rises); end
    tests_run++; if (o_blocks_done !== 24'd1 || o_error !== 8'h04 || o_error_flag !== 1'b1) begin tests_failed++;
      $display("FAIL crcfail_status: got done=%0d err=%02h flag=%0d want 1 04 1", o_blocks_done, o_error, o_error_flag); end
    tests_run++; if (gap_seen[0] !== 2) begin tests_failed++; $display("FAIL crcfail_gap: got %0d want 2", gap_seen[0]); end
  endtask

  task automatic test_abort();
    phy_auto = 1'b0;
    start_req(1'b1, 1'b1, 1'b0, 3'd1, 24'd3, 32'd0, 16'h0000);
    for (int k = 0; k < 10 && !phy_bus.o_phy_activate; k++) step();
    tests_run++; if (phy_bus.o_phy_activate !== 1'b1) begin tests_failed++;
      $display("FAIL abort_act_up: got %0d want 1", phy_bus.o_phy_activate); end
    step();
    phy_fin = 1'b1;
    i_abort = 1'b1;
    step();
    tests_run++; if (phy_bus.o_phy_activate !== 1'b0 || o_finished !== 1'b1) begin tests_failed++;
      $display("FAIL abort_act_drop: got act=%0d fin=%0d want 0 1", phy_bus.o_phy_activate, o_finished); end
    wait_fin(20, timed_out);
    phy_auto = 1'b1;
    tests_run++; if (timed_out !== 1'b0 || o_error !== 8'h08 || o_error_flag !== 1'b1) begin tests_failed++;
      $display("FAIL abort_err: got to=%0d err=%02h flag=%0d want 0 08 1", timed_out, o_error, o_error_flag); end
    tests_run++; if (o_blocks_done !== '0 || rises !== 1) begin tests_failed++;
      $display("FAIL abort_done: got done=%0d rises=%0d want 0 1", o_blocks_done, rises); end
    i_abort = 1'b1;
    step(); step();
    tests_run++; if (o_busy !== 1'b0 || o_error !== 8'h08) begin tests_failed++;
      $display("FAIL abort_idle: got busy=%0d err=%02h want 0 08", o_busy, o_error); end
  endtask

  task automatic test_size_errors();
    i_mem_block_size = 24'd0;
    start_req(1'b0, 1'b1, 1'b1, 3'd1, 24'd2, 32'd0, 16'h0000);
    wait_fin(50, timed_out);
    tests_run++; if (o_error !== 8'h02 || rises !== 0 || fin_pulses !== 1) begin tests_failed++;
      $display("FAIL memsize0: got err=%02h rises=%0d fin=%0d want 02 0 1", o_error, rises, fin_pulses); end
    start_req(1'b0, 1'b1, 1'b0, 3'd2, 24'd1, 32'd0, 16'h0000);
    wait_fin(50, timed_out);
    tests_run++; if (o_error !== 8'h02 || rises !== 0) begin tests_failed++;
      $display("FAIL tblsize5000: got err=%02h rises=%0d want 02 0", o_error, rises); end
    i_mem_block_size = 24'd4095;
    start_req(1'b0, 1'b1, 1'b1, 3'd0, 24'd1, 32'd0, 16'h0000);
    wait_fin(50, timed_out);
    tests_run++; if (o_error !== 8'h00 || rises !== 1 || bc_seen[0] !== 12'd4095) begin tests_failed++;
      $display("FAIL memsize4095: got err=%02h rises=%0d bc=%0d want 00 1 4095", o_error, rises, bc_seen[0]); end
    i_mem_block_size = 24'd4096;
    start_req(1'b0, 1'b1, 1'b1, 3'd0, 24'd1, 32'd0, 16'h0000);
    wait_fin(50, timed_out);
    tests_run++; if (o_error !== 8'h02 || rises !== 0) begin tests_failed++;
      $display("FAIL memsize4096: got err=%02h rises=%0d want 02 0", o_error, rises); end
    start_req(1'b0, 1'b1, 1'b0, 3'd1, 24'd0, 32'd0, 16'h0000);
    wait_fin(50, timed_out);
    tests_run++; if (timed_out !== 1'b0 || o_error !== 8'h00 || o_error_flag !== 1'b0 || rises !== 0) begin tests_failed++;
      $display("FAIL count0: got to=%0d err=%02h flag=%0d rises=%0d want 0 00 0 0", timed_out, o_error, o_error_flag, rises); end
  endtask

  task automatic test_busy_ignore();
    start_req(1'b0, 1'b1, 1'b0, 3'd3, 24'd2, 32'd3, 16'h0000);
    i_start = 1'b1; i_func_addr = 3'd1; i_data_size = 24'd5;
    step();
    wait_fin(200, timed_out);
    tests_run++; if (timed_out !== 1'b0 || rises !== 2 || bc_seen[1] !== 12'd16) begin tests_failed++;
      $display("FAIL busy_ignore: got to=%0d rises=%0d bc=%0d want 0 2 16", timed_out, rises, bc_seen[1]); end
    tests_run++; if (o_blocks_done !== 24'd2 || gap_seen[0] !== 3) begin tests_failed++;
      $display("FAIL busy_ignore_done: got done=%0d gap=%0d want 2 3", o_blocks_done, gap_seen[0]); end
  endtask

  task automatic test_reset_mid();
    start_req(1'b1, 1'b1, 1'b0, 3'd1, 24'd3, 32'd0, 16'h0000);
    for (int k = 0; k < 10 && !phy_bus.o_phy_activate; k++) step();
    rst_n = 1'b0;
    #1;
    tests_run++; if (phy_bus.o_phy_activate !== 1'b0 || o_busy !== 1'b0 || o_blocks_done !== '0) begin tests_failed++;
      $display("FAIL rst_mid: got act=%0d busy=%0d done=%0d want 0 0 0", phy_bus.o_phy_activate, o_busy, o_blocks_done); end
    step();
    rst_n = 1'b1;
    step();
    start_req(1'b0, 1'b1, 1'b0, 3'd3, 24'd1, 32'd0, 16'h0000);
    wait_fin(100, timed_out);
    tests_run++; if (timed_out !== 1'b0 || rises !== 1 || o_blocks_done !== 24'd1 || o_error !== 8'h00) begin tests_failed++;
      $display("FAIL rst_rerun: got to=%0d rises=%0d done=%0d err=%02h want 0 1 1 00", timed_out, rises, o_blocks_done, o_error); end
  endtask

  initial begin
    i_block_sizes[0*SW +: SW] = 24'd0;
    i_block_sizes[1*SW +: SW] = 24'd64;
    i_block_sizes[2*SW +: SW] = 24'd5000;
    i_block_sizes[3*SW +: SW] = 24'd16;
    for (int f = 4; f < NUM_FUNCS; f++) i_block_sizes[f*SW +: SW] = 24'd32;
    test_reset();
    test_block_mode();
    test_byte_mode();
    test_crc_retry();
    test_abort();
    test_size_errors();
    test_busy_ignore();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion by time limit, want all scenarios finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
